// File: rtl/decode_stage_ctrl.sv
// decode_stage_ctrl
//   Registered RV32IM main-decode stage with a 2-entry (main + skid) buffer.
//   Instructions are decoded combinationally on in_instr and the decoded
//   result is captured with the instruction on accept.
// Ports:
//   clk, rst_n                    clock (rising edge), async active-low reset
//   flush                         drop every buffered entry this edge
//   in_valid/in_ready             input handshake (in_ready is a register)
//   in_instr, in_pc               fetched instruction and its PC
//   out_valid/out_ready           output handshake
//   out_instr, out_pc             instruction and PC of the output entry
//   out_ctrl [18:0]               packed control bundle
//   illegal_instr                 output entry is an illegal encoding
//   decoded_count, illegal_count  wrapping handshake / illegal counters
module decode_stage_ctrl #(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [XLEN-1:0]  out_pc,
  output logic [18:0]      out_ctrl,
  output logic             illegal_instr,
  output logic [CNT_W-1:0] decoded_count,
  output logic [CNT_W-1:0] illegal_count
);

  // out_ctrl bit positions
  localparam int B_REG_WRITE = 0;
  localparam int B_ALU_SRC   = 1;
  localparam int B_MEM_WRITE = 2;
  localparam int B_MEM_READ  = 3;
  localparam int B_MEM_TO_REG = 4;
  localparam int B_BRANCH    = 5;
  localparam int B_JAL       = 6;
  localparam int B_JALR      = 7;
  localparam int B_LUI       = 8;
  localparam int B_AUIPC     = 9;
  localparam int B_MEM_UNS   = 10;
  localparam int B_MD_VALID  = 15;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MD   = 7'b0000001;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [18:0] dec_ctrl;
  logic        dec_illegal;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  // ---------------------------------------------------------------------
  // Combinational decode of the incoming instruction
  // ---------------------------------------------------------------------
  always_comb begin
    dec_ctrl    = '0;
    dec_illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_ctrl[B_REG_WRITE] = 1'b1;
        dec_ctrl[12:11]       = 2'b10;
        if (funct7 == F7_BASE) begin
          dec_illegal = 1'b0;
        end else if (funct7 == F7_ALT) begin
          // only SUB and SRA use the alternate funct7
          dec_illegal = !(funct3 == 3'b000 || funct3 == 3'b101);
        end else if (funct7 == F7_MD && ENABLE_M != 0) begin
          dec_ctrl[B_MD_VALID] = 1'b1;
          dec_ctrl[18:16]      = funct3;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec_ctrl[B_REG_WRITE] = 1'b1;
        dec_ctrl[B_ALU_SRC]   = 1'b1;
        dec_ctrl[12:11]       = 2'b10;
        // shift-immediates reuse funct7 as an encoding field
        if (funct3 == 3'b001 && funct7 != F7_BASE)
          dec_illegal = 1'b1;
        if (funct3 == 3'b101 && funct7 != F7_BASE && funct7 != F7_ALT)
          dec_illegal = 1'b1;
      end
      OPC_LOAD: begin
        dec_ctrl[B_REG_WRITE]  = 1'b1;
        dec_ctrl[B_ALU_SRC]    = 1'b1;
        dec_ctrl[B_MEM_READ]   = 1'b1;
        dec_ctrl[B_MEM_TO_REG] = 1'b1;
        case (funct3)
          3'b000:  dec_ctrl[14:13] = 2'b10;
          3'b001:  dec_ctrl[14:13] = 2'b01;
          3'b010:  dec_ctrl[14:13] = 2'b00;
          3'b100: begin
            dec_ctrl[14:13]    = 2'b10;
            dec_ctrl[B_MEM_UNS] = 1'b1;
          end
          3'b101: begin
            dec_ctrl[14:13]    = 2'b01;
            dec_ctrl[B_MEM_UNS] = 1'b1;
          end
          default: dec_illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        dec_ctrl[B_ALU_SRC]   = 1'b1;
        dec_ctrl[B_MEM_WRITE] = 1'b1;
        case (funct3)
          3'b000:  dec_ctrl[14:13] = 2'b10;
          3'b001:  dec_ctrl[14:13] = 2'b01;
          3'b010:  dec_ctrl[14:13] = 2'b00;
          default: dec_illegal = 1'b1;
        endcase
      end
      OPC_BRANCH: begin
        dec_ctrl[B_BRANCH] = 1'b1;
        dec_ctrl[12:11]    = 2'b01;
        if (funct3 == 3'b010 || funct3 == 3'b011)
          dec_illegal = 1'b1;
      end
      OPC_LUI: begin
        dec_ctrl[B_LUI]       = 1'b1;
        dec_ctrl[B_REG_WRITE] = 1'b1;
      end
      OPC_AUIPC: begin
        dec_ctrl[B_AUIPC]     = 1'b1;
        dec_ctrl[B_REG_WRITE] = 1'b1;
      end
      OPC_JAL: begin
        dec_ctrl[B_JAL]       = 1'b1;
        dec_ctrl[B_REG_WRITE] = 1'b1;
      end
      OPC_JALR: begin
        dec_ctrl[B_JALR]      = 1'b1;
        dec_ctrl[B_REG_WRITE] = 1'b1;
        dec_ctrl[B_ALU_SRC]   = 1'b1;
        if (funct3 != 3'b000)
          dec_illegal = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
    // writes to x0 are architecturally discarded
    if (rd == 5'd0)
      dec_ctrl[B_REG_WRITE] = 1'b0;
    // illegal entries carry no control so nothing downstream acts on them
    if (dec_illegal)
      dec_ctrl = '0;
  end

  // ---------------------------------------------------------------------
  // Main + skid storage
  // ---------------------------------------------------------------------
  logic             main_valid_reg, skid_valid_reg;
  logic [31:0]      main_instr_reg, skid_instr_reg;
  logic [XLEN-1:0]  main_pc_reg,    skid_pc_reg;
  logic [18:0]      main_ctrl_reg,  skid_ctrl_reg;
  logic             main_ill_reg,   skid_ill_reg;
  logic [CNT_W-1:0] dec_cnt_reg,    ill_cnt_reg;

  logic accept;
  logic fire;
  logic main_free;

  assign accept    = in_valid && !skid_valid_reg && !flush;
  assign fire      = main_valid_reg && out_ready && !flush;
  assign main_free = !main_valid_reg || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      main_instr_reg <= '0;
      main_pc_reg    <= '0;
      main_ctrl_reg  <= '0;
      main_ill_reg   <= 1'b0;
      skid_instr_reg <= '0;
      skid_pc_reg    <= '0;
      skid_ctrl_reg  <= '0;
      skid_ill_reg   <= 1'b0;
    end else if (flush) begin
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (main_free) begin
      if (skid_valid_reg) begin
        // skid refills main; a same-edge accept takes the freed skid slot
        main_valid_reg <= 1'b1;
        main_instr_reg <= skid_instr_reg;
        main_pc_reg    <= skid_pc_reg;
        main_ctrl_reg  <= skid_ctrl_reg;
        main_ill_reg   <= skid_ill_reg;
        skid_valid_reg <= accept;
        if (accept) begin
          skid_instr_reg <= in_instr;
          skid_pc_reg    <= in_pc;
          skid_ctrl_reg  <= dec_ctrl;
          skid_ill_reg   <= dec_illegal;
        end
      end else begin
        main_valid_reg <= accept;
        if (accept) begin
          main_instr_reg <= in_instr;
          main_pc_reg    <= in_pc;
          main_ctrl_reg  <= dec_ctrl;
          main_ill_reg   <= dec_illegal;
        end
      end
    end else if (accept) begin
      // main is stalled: park the new entry in skid
      skid_valid_reg <= 1'b1;
      skid_instr_reg <= in_instr;
      skid_pc_reg    <= in_pc;
      skid_ctrl_reg  <= dec_ctrl;
      skid_ill_reg   <= dec_illegal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_cnt_reg <= '0;
      ill_cnt_reg <= '0;
    end else if (fire) begin
      dec_cnt_reg <= dec_cnt_reg + CNT_W'(1);
      if (main_ill_reg)
        ill_cnt_reg <= ill_cnt_reg + CNT_W'(1);
    end
  end

  assign in_ready      = !skid_valid_reg;
  assign out_valid     = main_valid_reg;
  assign out_instr     = main_instr_reg;
  assign out_pc        = main_pc_reg;
  assign out_ctrl      = main_ctrl_reg;
  assign illegal_instr = main_ill_reg;
  assign decoded_count = dec_cnt_reg;
  assign illegal_count = ill_cnt_reg;

endmodule

// File: tb/tb_decode_stage_ctrl.sv
// Directed bench for decode_stage_ctrl: a default instance, an ENABLE_M=0
// instance and a CNT_W=4 instance all share the same stimulus.
module tb_decode_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, illegal_instr;
  logic [31:0] out_instr, out_pc;
  logic [18:0] out_ctrl;
  logic [15:0] decoded_count, illegal_count;

  logic        n_in_ready, n_out_valid, n_illegal;
  logic [31:0] n_out_instr, n_out_pc;
  logic [18:0] n_out_ctrl;
  logic [15:0] n_dec_cnt, n_ill_cnt;

  logic        c_in_ready, c_out_valid, c_illegal;
  logic [31:0] c_out_instr, c_out_pc;
  logic [18:0] c_out_ctrl;
  logic [3:0]  c_dec_cnt, c_ill_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decode_stage_ctrl #(.XLEN(32), .ENABLE_M(1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_ctrl(out_ctrl), .illegal_instr(illegal_instr),
    .decoded_count(decoded_count), .illegal_count(illegal_count)
  );

  decode_stage_ctrl #(.XLEN(32), .ENABLE_M(0), .CNT_W(16)) dut_nom (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(n_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(n_out_valid), .out_ready(out_ready), .out_instr(n_out_instr),
    .out_pc(n_out_pc), .out_ctrl(n_out_ctrl), .illegal_instr(n_illegal),
    .decoded_count(n_dec_cnt), .illegal_count(n_ill_cnt)
  );

  decode_stage_ctrl #(.XLEN(32), .ENABLE_M(1), .CNT_W(4)) dut_c4 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(c_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(c_out_valid), .out_ready(out_ready), .out_instr(c_out_instr),
    .out_pc(c_out_pc), .out_ctrl(c_out_ctrl), .illegal_instr(c_illegal),
    .decoded_count(c_dec_cnt), .illegal_count(c_ill_cnt)
  );

  // advance one rising edge, then settle 1 time unit past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // present one instruction for one edge with out_ready high, main empty
  task automatic push_one(input logic [31:0] instr, input logic [31:0] pc);
    in_valid  = 1'b1;
    in_instr  = instr;
    in_pc     = pc;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic decode_check(input string name, input logic [31:0] instr,
                              input logic [18:0] exp_ctrl, input logic exp_ill);
    push_one(instr, 32'h1000);
    checks++;
    if (out_valid !== 1'b1 || out_ctrl !== exp_ctrl || illegal_instr !== exp_ill ||
        out_instr !== instr) begin
      failures++;
      $display("FAIL %s: valid=%b ctrl=%h ill=%b instr=%h, required valid=1 ctrl=%h ill=%b instr=%h",
               name, out_valid, out_ctrl, illegal_instr, out_instr, exp_ctrl, exp_ill, instr);
    end else
      $display("ok   %s: instr=%h ctrl=%h ill=%b", name, instr, out_ctrl, illegal_instr);
    step();   // drain the entry
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_ctrl !== '0 || illegal_instr !== 1'b0 ||
        out_instr !== '0 || out_pc !== '0 || decoded_count !== '0 || illegal_count !== '0) begin
      failures++;
      $display("FAIL reset: valid=%b rdy=%b ctrl=%h ill=%b instr=%h pc=%h dc=%0d ic=%0d, required rdy=1 rest 0",
               out_valid, in_ready, out_ctrl, illegal_instr, out_instr, out_pc, decoded_count, illegal_count);
    end else
      $display("ok   reset: outputs zero, in_ready=1");
    #9 rst_n = 1'b1;   // release away from a clock edge
  endtask

  task automatic test_decode();
    decode_check("add",     32'h003100B3, 19'h01001, 1'b0);
    decode_check("lbu",     32'h00034283, 19'h0441B, 1'b0);
    decode_check("sw",      32'h0020A023, 19'h00006, 1'b0);
    decode_check("beq",     32'h00000063, 19'h00820, 1'b0);
    decode_check("jal_x0",  32'h0000006F, 19'h00040, 1'b0);
  endtask

  task automatic test_m_ext();
    push_one(32'h023100B3, 32'h2000);
    checks++;
    if (out_ctrl !== 19'h09001 || illegal_instr !== 1'b0) begin
      failures++;
      $display("FAIL mul_m1: ctrl=%h ill=%b, required ctrl=09001 ill=0", out_ctrl, illegal_instr);
    end else
      $display("ok   mul_m1: ctrl=%h", out_ctrl);
    checks++;
    if (n_out_valid !== 1'b1 || n_out_ctrl !== '0 || n_illegal !== 1'b1) begin
      failures++;
      $display("FAIL mul_m0: valid=%b ctrl=%h ill=%b, required valid=1 ctrl=00000 ill=1",
               n_out_valid, n_out_ctrl, n_illegal);
    end else
      $display("ok   mul_m0: flagged illegal");
    step();
    checks++;
    if (n_ill_cnt !== 16'd1 || illegal_count !== 16'd0 || decoded_count !== 16'd6) begin
      failures++;
      $display("FAIL mul_counts: m0_ill=%0d m1_ill=%0d dec=%0d, required 1 0 6",
               n_ill_cnt, illegal_count, decoded_count);
    end else
      $display("ok   mul_counts: m0_ill=%0d dec=%0d", n_ill_cnt, decoded_count);
  endtask

  task automatic test_illegal();
    decode_check("zero_word", 32'h00000000, 19'h00000, 1'b1);
    decode_check("addi_x0",   32'h00000013, 19'h01002, 1'b0);
    decode_check("load_f3_3", 32'h00003003, 19'h00000, 1'b1);
    checks++;
    if (illegal_count !== 16'd2 || n_ill_cnt !== 16'd3 || decoded_count !== 16'd9) begin
      failures++;
      $display("FAIL illegal_counts: ill=%0d m0_ill=%0d dec=%0d, required 2 3 9",
               illegal_count, n_ill_cnt, decoded_count);
    end else
      $display("ok   illegal_counts: ill=%0d dec=%0d", illegal_count, decoded_count);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00100093;  // addi x1,x0,1
    in_pc     = 32'h100;
    step();
    in_instr  = 32'h00200113;  // addi x2,x0,2
    in_pc     = 32'h104;
    step();
    checks++;
    if (out_instr !== 32'h00100093 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_full: instr=%h rdy=%b valid=%b, required instr=00100093 rdy=0 valid=1",
               out_instr, in_ready, out_valid);
    end else
      $display("ok   bp_full: first held, skid full");
    in_instr = 32'h00300193;   // addi x3,x0,3 -- must not be taken yet
    in_pc    = 32'h108;
    step();
    checks++;
    if (out_instr !== 32'h00100093 || out_pc !== 32'h100 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_hold: instr=%h pc=%h rdy=%b, required 00100093 100 rdy=0",
               out_instr, out_pc, in_ready);
    end else
      $display("ok   bp_hold: output stable");
    out_ready = 1'b1;
    step();
    checks++;
    if (out_instr !== 32'h00200113 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_out2: instr=%h valid=%b rdy=%b, required 00200113 1 1",
               out_instr, out_valid, in_ready);
    end else
      $display("ok   bp_out2: instr=%h", out_instr);
    step();
    in_valid = 1'b0;
    checks++;
    if (out_instr !== 32'h00300193 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_out3: instr=%h valid=%b, required 00300193 1", out_instr, out_valid);
    end else
      $display("ok   bp_out3: instr=%h", out_instr);
    step();
    checks++;
    if (out_valid !== 1'b0 || decoded_count !== 16'd12) begin
      failures++;
      $display("FAIL bp_count: valid=%b dec=%0d, required 0 12", out_valid, decoded_count);
    end else
      $display("ok   bp_count: dec=%0d", decoded_count);
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00400213;
    step();
    in_instr  = 32'h00500293;
    step();
    in_instr  = 32'h00600313;
    flush     = 1'b1;
    out_ready = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || decoded_count !== 16'd12 ||
        illegal_count !== 16'd2) begin
      failures++;
      $display("FAIL flush: valid=%b rdy=%b dec=%0d ill=%0d, required 0 1 12 2",
               out_valid, in_ready, decoded_count, illegal_count);
    end else
      $display("ok   flush: buffers empty, counters held");
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_drop: valid=%b, required 0", out_valid);
    end else
      $display("ok   flush_drop: same-cycle accept dropped");
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00700393;
    in_pc     = 32'h200;
    step();
    in_instr  = 32'h00800413;
    step();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_ctrl !== '0 || out_instr !== '0 ||
        out_pc !== '0 || decoded_count !== '0 || illegal_count !== '0) begin
      failures++;
      $display("FAIL async_reset: valid=%b rdy=%b ctrl=%h instr=%h pc=%h dc=%0d ic=%0d, required rdy=1 rest 0",
               out_valid, in_ready, out_ctrl, out_instr, out_pc, decoded_count, illegal_count);
    end else
      $display("ok   async_reset: cleared without a clock edge");
    #2 rst_n = 1'b1;
  endtask

  task automatic test_counter_wrap();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_instr = 32'h00000093 | (32'(i) << 20);
      in_pc    = 32'(i) << 2;
      step();
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (c_dec_cnt !== 4'd1 || decoded_count !== 16'd17) begin
      failures++;
      $display("FAIL wrap: cnt4=%0d cnt16=%0d, required 1 17", c_dec_cnt, decoded_count);
    end else
      $display("ok   wrap: cnt4=%0d cnt16=%0d", c_dec_cnt, decoded_count);
  endtask

  initial begin
    test_reset();
    step();
    test_decode();
    test_m_ext();
    test_illegal();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_counter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage_ctrl.md
Name: decode_stage_ctrl

Overview:
Registered, parametrised main-decode stage for the RV32IM pipeline. It accepts fetched instructions over a valid/ready handshake and decodes opcode, funct3 and funct7 into the packed control bundle. It also detects illegal encodings, optionally supports the M extension, and keeps decode/illegal event counters. It sits between the IF/ID boundary and the register-file read stage, and absorbs back-pressure with a 2-entry skid buffer so `in_ready` is registered.

Parameters:
XLEN, 32, width of PC path
ENABLE_M, 1, 1 = MUL/DIV encodings legal and md_valid asserted; 0 = they decode as illegal
CNT_W, 16, width of decoded_count and illegal_count (wrap modulo 2^CNT_W)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  drop all buffered instructions (branch redirect / trap)
in_valid  input  1  instruction present on in_instr/in_pc
in_ready  output  1  stage can accept (registered)
in_instr  input  32  raw instruction
in_pc  input  XLEN  instruction PC
out_valid  output  1  decoded entry present
out_ready  input  1  downstream accepts
out_instr  output  32  instruction of output entry
out_pc  output  XLEN  PC of output entry
out_ctrl  output  19  packed control bundle (layout below)
illegal_instr  output  1  output entry is an illegal encoding
decoded_count  output  CNT_W  number of out handshakes
illegal_count  output  CNT_W  number of out handshakes with illegal_instr=1

Behaviour:
- out_ctrl packing:
  - [0] reg_write, [1] alu_src, [2] mem_write, [3] mem_read, [4] mem_to_reg
  - [5] branch, [6] jal, [7] jalr, [8] lui, [9] auipc, [10] mem_unsigned
  - [12:11] alu_op, [14:13] mem_size, [15] md_valid, [18:16] md_operation
- Encodings:
  - alu_op: 00 load/store, 01 branch, 10 OP/OP-IMM, 00 otherwise.
  - mem_size: 00 word, 01 half, 10 byte.
  - md_operation = funct3 for OP with funct7=0000001.
- Control per opcode:
  - OP 0110011: reg_write, alu_op=10.
  - OP-IMM 0010011: reg_write, alu_src, alu_op=10.
  - LOAD 0000011: alu_src, mem_read, mem_to_reg, reg_write; mem_size/mem_unsigned from funct3 (LB/LH/LW/LBU/LHU).
  - STORE 0100011: alu_src, mem_write; mem_size from funct3.
  - BRANCH 1100011: branch, alu_op=01.
  - LUI 0110111: lui, reg_write. AUIPC 0010111: auipc, reg_write.
  - JAL 1101111: jal, reg_write. JALR 1100111: jalr, reg_write, alu_src.
- Illegal, when any of these holds:
  - opcode not in the list above;
  - LOAD funct3 ∈ {011,110,111};
  - STORE funct3 > 010;
  - BRANCH funct3 ∈ {010,011};
  - JALR funct3 ≠ 000;
  - OP funct7 ∉ {0000000, 0100000 (funct3 000/101 only), 0000001 (only if ENABLE_M)};
  - OP-IMM funct3=001 with funct7≠0000000, or funct3=101 with funct7 ∉ {0000000,0100000}.
- Illegal entry handling: out_ctrl = all zero, illegal_instr = 1, entry still delivered (out_valid) so trap logic sees it.
- rd==x0: reg_write forced 0 in every case, including JAL/JALR/LUI; md_valid unaffected.
- Storage: main register (drives outputs) plus skid register. Decode is combinational on in_instr and registered on accept.
- Accept condition: in_valid && in_ready.
  - If main is empty or out_ready=1, the entry goes to main.
  - Otherwise it goes to skid.
  - When main drains (out_ready=1) and skid is valid, skid moves to main in the same edge; a simultaneous accept then goes to skid.
- in_ready = !skid_valid, registered. Full = skid valid.
- Latency: accept at edge N → out_valid at N (post-edge), i.e. 1 cycle from in_valid to out_valid. Throughput 1/cycle with out_ready held high.
- Output stability: out_* stable while out_valid && !out_ready.
- flush: both valid bits cleared at the edge; any same-cycle accept is dropped; counters do not count a handshake in that cycle. in_ready=1 the following cycle.
- Counters:
  - decoded_count += 1 on out_valid && out_ready && !flush.
  - illegal_count additionally requires illegal_instr.
  - Both wrap at 2^CNT_W.
- Reset (async, rst_n=0): both valid bits 0, in_ready 1, out_valid 0, out_ctrl 0, illegal_instr 0, out_instr/out_pc 0, counters 0. Reset mid-stall discards buffered entries.

Test Plan:
- Decode, out_ready=1: 0x003100B3 (ADD x1,x2,x3) → out_valid next cycle, out_ctrl reg_write=1, alu_op=10, md_valid=0, illegal_instr=0. 0x00034283 (LBU x5,0(x6)) → mem_read=1, mem_to_reg=1, mem_size=10, mem_unsigned=1.
- M extension: 0x023100B3 (MUL) with ENABLE_M=1 → md_valid=1, md_operation=000. Same instruction with ENABLE_M=0 → illegal_instr=1, out_ctrl=0, illegal_count=1.
- Illegal and x0 handling: 0x00000000 → illegal_instr=1, out_ctrl=0. 0x00000013 (ADDI x0) → reg_write=0, alu_src=1, illegal_instr=0.
- Back-pressure: out_ready=0, stream 3 instructions back-to-back → first held at output, second in skid, in_ready=0 after second accept, third not accepted. Raise out_ready → 3 outputs in order on consecutive cycles, decoded_count=3.
- Flush: assert flush with main and skid full and in_valid=1 → next cycle out_valid=0, in_ready=1, counters unchanged.
- Reset: pull rst_n low asynchronously mid-stall → all outputs 0 immediately, in_ready=1. Counter wrap with CNT_W=4: 17 handshakes → decoded_count=1.
